// File: rtl/fsm_pattern_tx.sv
// Sync-marked serial frame transmitter: 0110 sync, MSB-first payload, optional parity, stop bit.
// Optional feature: define PARITY_EN to compile in the even-parity bit after the payload.
module fsm_pattern_tx #(
    parameter int unsigned DATA_W       = 8,
    parameter int unsigned CLKS_PER_BIT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              out,
    output logic              busy,
    output logic              done
);
    // One counter serves as the 2-bit sync index and as the payload bit counter.
    localparam int unsigned CntMax = (DATA_W > 4) ? DATA_W : 4;
    localparam int unsigned CntW   = $clog2(CntMax);
    localparam int unsigned DivW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    localparam logic [CntW-1:0] LastData = CntW'(DATA_W - 1);
    localparam logic [CntW-1:0] LastSync = CntW'(3);
    localparam logic [DivW-1:0] LastDiv  = DivW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StSync   = 3'd1,
        StData   = 3'd2,
`ifdef PARITY_EN
        StParity = 3'd3,
`endif
        StStop   = 3'd4
    } state_e;

    state_e            state_q;
    logic [DATA_W-1:0] shift_q;
    logic [CntW-1:0]   cnt_q;
    logic [DivW-1:0]   div_q;
`ifdef PARITY_EN
    logic              parity_q;
`endif

    logic              bit_end;
    logic [DATA_W-1:0] shift_nxt;
    logic [1:0]        sync_idx_nxt;
    logic              sync_bit_nxt;

    assign tx_ready     = (state_q == StIdle);
    assign bit_end      = (div_q == LastDiv);
    assign shift_nxt    = shift_q << 1;
    assign sync_idx_nxt = cnt_q[1:0] + 2'd1;
    // Pattern 0110 indexed 0..3 equals the XOR of the index bits.
    assign sync_bit_nxt = sync_idx_nxt[1] ^ sync_idx_nxt[0];

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= StIdle;
            shift_q  <= '0;
            cnt_q    <= '0;
            div_q    <= '0;
            out      <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
`ifdef PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            if (state_q != StIdle) begin
                div_q <= bit_end ? '0 : div_q + 1'b1;
            end
            case (state_q)
                StIdle: begin
                    out  <= 1'b1;
                    busy <= 1'b0;
                    if (tx_valid) begin
                        shift_q  <= tx_data;
`ifdef PARITY_EN
                        parity_q <= ^tx_data;
`endif
                        cnt_q    <= '0;
                        div_q    <= '0;
                        out      <= 1'b0;
                        busy     <= 1'b1;
                        state_q  <= StSync;
                    end
                end
                StSync: begin
                    if (bit_end) begin
                        if (cnt_q == LastSync) begin
                            cnt_q   <= '0;
                            out     <= shift_q[DATA_W-1];
                            state_q <= StData;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                            out   <= sync_bit_nxt;
                        end
                    end
                end
                StData: begin
                    if (bit_end) begin
                        if (cnt_q == LastData) begin
                            cnt_q   <= '0;
`ifdef PARITY_EN
                            out     <= parity_q;
                            state_q <= StParity;
`else
                            out     <= 1'b1;
                            state_q <= StStop;
`endif
                        end else begin
                            cnt_q   <= cnt_q + 1'b1;
                            shift_q <= shift_nxt;
                            out     <= shift_nxt[DATA_W-1];
                        end
                    end
                end
`ifdef PARITY_EN
                StParity: begin
                    if (bit_end) begin
                        out     <= 1'b1;
                        state_q <= StStop;
                    end
                end
`endif
                StStop: begin
                    if (bit_end) begin
                        out     <= 1'b1;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state_q <= StIdle;
                    end
                end
                default: begin
                    out     <= 1'b1;
                    busy    <= 1'b0;
                    cnt_q   <= '0;
                    div_q   <= '0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fsm_pattern_tx.sv
// Self-checking bench for fsm_pattern_tx: one DUT at 1 clock/bit and one at 3 clocks/bit,
// compared cycle by cycle against frames built from the framing rules.
module tb_fsm_pattern_tx;
    localparam int unsigned DataW = 8;
`ifdef PARITY_EN
    localparam int unsigned ParBits = 1;
`else
    localparam int unsigned ParBits = 0;
`endif
    localparam int unsigned FrameBits = 4 + DataW + ParBits + 1;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic [DataW-1:0] tx_data = '0;
    logic             valid_a = 1'b0;
    logic             valid_b = 1'b0;
    logic             ready_a, out_a, busy_a, done_a;
    logic             ready_b, out_b, busy_b, done_b;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    fsm_pattern_tx #(.DATA_W(DataW), .CLKS_PER_BIT(1)) dut_a (
        .clk(clk), .reset(reset), .tx_data(tx_data), .tx_valid(valid_a),
        .tx_ready(ready_a), .out(out_a), .busy(busy_a), .done(done_a)
    );

    fsm_pattern_tx #(.DATA_W(DataW), .CLKS_PER_BIT(3)) dut_b (
        .clk(clk), .reset(reset), .tx_data(tx_data), .tx_valid(valid_b),
        .tx_ready(ready_b), .out(out_b), .busy(busy_b), .done(done_b)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Entered in an IDLE cycle; returns in the IDLE/done cycle after the frame.
    task automatic drive_frame(input bit slow, input logic [DataW-1:0] d, input bit keep,
                               input logic [DataW-1:0] next_d, input bit watch_detect);
        int   cpb;
        logic exp_bits[$];
        logic o, b, dn, r;
        logic [3:0] win;
        cpb = slow ? 3 : 1;
        exp_bits = {1'b0, 1'b1, 1'b1, 1'b0};
        for (int k = DataW - 1; k >= 0; k--) exp_bits.push_back(d[k]);
        if (ParBits == 1) exp_bits.push_back(^d);
        exp_bits.push_back(1'b1);
        tx_data = d;
        if (slow) valid_b = 1'b1; else valid_a = 1'b1;
        step();
        win = 4'b1111;
        for (int i = 0; i < int'(FrameBits) * cpb; i++) begin
            if (keep) begin
                tx_data = next_d;
            end else begin
                tx_data = DataW'($urandom);
                if (slow) valid_b = 1'($urandom); else valid_a = 1'($urandom);
            end
            o  = slow ? out_b : out_a;
            b  = slow ? busy_b : busy_a;
            dn = slow ? done_b : done_a;
            r  = slow ? ready_b : ready_a;
            vectors++;
            if (o !== exp_bits[i / cpb] || b !== 1'b1 || dn !== 1'b0 || r !== 1'b0) begin
                miscompares++;
                $display("FAIL frame d=%h cpb=%0d cycle %0d: out,busy,done,ready got %b%b%b%b want %b100",
                         d, cpb, i, o, b, dn, r, exp_bits[i / cpb]);
            end
            if (watch_detect) begin
                win = {win[2:0], o};
                vectors++;
                if ((win == 4'b0110) !== (i == 3)) begin
                    miscompares++;
                    $display("FAIL loopback detect cycle %0d: window got %b, detect expected %b",
                             i, win, (i == 3));
                end
            end
            step();
        end
        o  = slow ? out_b : out_a;
        b  = slow ? busy_b : busy_a;
        dn = slow ? done_b : done_a;
        r  = slow ? ready_b : ready_a;
        vectors++;
        if (o !== 1'b1 || b !== 1'b0 || dn !== 1'b1 || r !== 1'b1) begin
            miscompares++;
            $display("FAIL end-of-frame d=%h: out,busy,done,ready got %b%b%b%b want 1011",
                     d, o, b, dn, r);
        end
        if (!keep) begin
            valid_a = 1'b0;
            valid_b = 1'b0;
        end
    endtask

    task automatic check_idle_a(input string name);
        vectors++;
        if (out_a !== 1'b1 || busy_a !== 1'b0 || done_a !== 1'b0 || ready_a !== 1'b1) begin
            miscompares++;
            $display("FAIL %s: out,busy,done,ready got %b%b%b%b want 1001",
                     name, out_a, busy_a, done_a, ready_a);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        step();
        step();
        check_idle_a("reset dut_a");
        vectors++;
        if (out_b !== 1'b1 || busy_b !== 1'b0 || done_b !== 1'b0 || ready_b !== 1'b1) begin
            miscompares++;
            $display("FAIL reset dut_b: out,busy,done,ready got %b%b%b%b want 1001",
                     out_b, busy_b, done_b, ready_b);
        end
        reset = 1'b1;
        step();
        check_idle_a("post-reset idle");
    endtask

    task automatic test_basic();
        drive_frame(1'b0, 8'hA5, 1'b0, 8'h00, 1'b0);
        step();
        check_idle_a("done single pulse");
    endtask

    task automatic test_parity();
        drive_frame(1'b0, 8'h07, 1'b0, 8'h00, 1'b0);
        drive_frame(1'b0, 8'hA5, 1'b0, 8'h00, 1'b0);
        step();
    endtask

    task automatic test_slow_clock();
        drive_frame(1'b1, 8'hFF, 1'b0, 8'h00, 1'b0);
        step();
    endtask

    task automatic test_back_to_back();
        drive_frame(1'b0, 8'h3C, 1'b1, 8'hC3, 1'b0);
        drive_frame(1'b0, 8'hC3, 1'b0, 8'h00, 1'b0);
        step();
        check_idle_a("after back-to-back");
    endtask

    task automatic test_reset_mid_frame();
        tx_data = 8'h96;
        valid_a = 1'b1;
        step();
        valid_a = 1'b0;
        for (int i = 0; i < 7; i++) step();
        vectors++;
        if (busy_a !== 1'b1 || out_a !== 1'b1) begin
            miscompares++;
            $display("FAIL data bit 3 before reset: busy,out got %b%b want 11", busy_a, out_a);
        end
        reset = 1'b0;
        step();
        check_idle_a("reset mid-frame");
        reset = 1'b1;
        step();
        check_idle_a("no done after abort");
        drive_frame(1'b0, 8'h5A, 1'b0, 8'h00, 1'b0);
        step();
    endtask

    task automatic test_loopback();
        drive_frame(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
        step();
    endtask

    task automatic test_random();
        for (int n = 0; n < 6; n++) begin
            drive_frame(1'($urandom), DataW'($urandom), 1'b0, 8'h00, 1'b0);
            for (int g = 0; g < int'($urandom_range(0, 2)); g++) step();
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_parity();
        test_slow_clock();
        test_back_to_back();
        test_reset_mid_frame();
        test_loopback();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
